hazard_scoreboard: RTL

Parametrised load-use and long-latency hazard detector for the rv32i pipeline, sitting between decode and execute. A per-register countdown scoreboard replaces single-cycle load/EX comparison. It tracks every in-flight producer whose result is not yet forwardable and stalls decode until each source it reads can be forwarded. It also blocks write-after-write reordering against longer-latency producers and exports a pending mask plus a stall performance counter.

---
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register countdown scoreboard between decode and execute. Every
//   in-flight producer whose result cannot yet be forwarded is tracked as a
//   countdown. Decode is stalled when:
//     - a source it reads is still counting down, or
//     - its destination is still owed to an older, longer-latency producer.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   de_valid                   decode slot holds a real instruction
//   de_opcode                  decode opcode (rv32i base opcodes)
//   de_rs1_s, de_rs2_s         decode source register indices
//   de_rd_s                    decode destination index
//   de_long                    decode op is long-latency (M-extension)
//   flush                      decode instruction squashed this cycle
//   freeze                     whole pipeline held; scoreboard holds state
//   stall                      hold IF/DE, bubble into EX
//   rs1_hazard, rs2_hazard     source that caused the stall
//   waw_hazard                 destination conflict caused the stall
//   pending_mask               bit r set while register r is counting down
//   stall_cycles               cycles with stall=1 and freeze=0 (wraps)

module hazard_scoreboard #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned LONG_LAT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_valid,
  input  logic [6:0]  de_opcode,
  input  logic [4:0]  de_rs1_s,
  input  logic [4:0]  de_rs2_s,
  input  logic [4:0]  de_rd_s,
  input  logic        de_long,
  input  logic        flush,
  input  logic        freeze,
  output logic        stall,
  output logic        rs1_hazard,
  output logic        rs2_hazard,
  output logic        waw_hazard,
  output logic [31:0] pending_mask,
  output logic [31:0] stall_cycles
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] LONG_LAT_C = CNT_W'(LONG_LAT);

  logic [CNT_W-1:0] cnt_q [32];

  logic             uses_rs1;
  logic             uses_rs2;
  logic             writes_rd;
  logic             is_load;
  logic             is_reg;
  logic [CNT_W-1:0] issue_lat;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic             issue;
  logic             set_rd;

  // Source/destination usage from the opcode.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_reg    = 1'b0;
    case (de_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        writes_rd = 1'b1;
      end
      OP_JALR, OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_BR, OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        is_reg    = 1'b1;
      end
      default: begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  always_comb begin
    issue_lat = '0;
    if (is_load) begin
      issue_lat = LOAD_LAT_C;
    end else if (is_reg && de_long) begin
      issue_lat = LONG_LAT_C;
    end
  end

  // Entry 0 is never written, so x0 reads back as idle; the explicit
  // index checks below keep that independent of the storage.
  assign cnt_rs1 = cnt_q[de_rs1_s];
  assign cnt_rs2 = cnt_q[de_rs2_s];
  assign cnt_rd  = cnt_q[de_rd_s];

  assign rs1_hazard = de_valid && uses_rs1 && (de_rs1_s != 5'd0) && (cnt_rs1 != '0);
  assign rs2_hazard = de_valid && uses_rs2 && (de_rs2_s != 5'd0) && (cnt_rs2 != '0);
  // A writer that will itself become forwardable no earlier than the older
  // producer cannot be overtaken by it, so only a strictly longer
  // remaining count is a conflict.
  assign waw_hazard = de_valid && writes_rd && (de_rd_s != 5'd0) && (cnt_rd > issue_lat);

  assign stall  = rs1_hazard || rs2_hazard || waw_hazard;
  assign issue  = de_valid && !stall && !flush && !freeze;
  assign set_rd = issue && writes_rd && (de_rd_s != 5'd0) && (issue_lat != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else if (!freeze) begin
      cnt_q[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        // A fresh issue to the same register overrides its decrement.
        if (set_rd && (de_rd_s == 5'(r))) begin
          cnt_q[r] <= issue_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < 32; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && !freeze) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
